// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI responder.
//   - SD command indices understood by the responder
//   - R1 response bit positions and a helper to build an R1 byte
//   - data start token, OCR value and the idle fill byte
//   - responder FSM state encoding
package sd_spi_pkg;

  localparam logic [5:0] CMD_GO_IDLE         = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND    = 6'd8;
  localparam logic [5:0] CMD_READ_SINGLE     = 6'd17;
  localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
  localparam logic [5:0] CMD_APP_CMD         = 6'd55;
  localparam logic [5:0] CMD_READ_OCR        = 6'd58;

  localparam int R1_IDLE_BIT    = 0;
  localparam int R1_ILLEGAL_BIT = 2;

  localparam logic [7:0]  START_TOKEN = 8'hFE;
  localparam logic [7:0]  FILL_BYTE   = 8'hFF;
  localparam logic [31:0] OCR_VALUE   = 32'hC0FF8000;

  typedef enum logic [3:0] {
    WAIT_CMD,
    RX_CMD,
    NCR,
    TX_R1,
    TX_EXTRA,
    TX_GAP,
    TX_TOKEN,
    TX_DATA,
    TX_CRC
  } sd_state_e;

  function automatic logic [7:0] r1_byte(input logic illegal, input logic idle);
    logic [7:0] r;
    r                 = 8'h00;
    r[R1_ILLEGAL_BIT] = illegal;
    r[R1_IDLE_BIT]    = idle;
    return r;
  endfunction

endpackage

// File: rtl/sd_spi_byte_phy.sv
// Byte-level SPI mode-0 slave front end, running entirely on clk.
// Ports:
//   clk, reset        system clock, async active-high reset
//   cs, sclk, mosi    raw host pins (synchronized here)
//   tx_byte           next byte to put on miso, sampled at each byte boundary
//   miso              serial output, forced high while cs is high
//   cs_active         synchronized chip select is asserted (low)
//   byte_done         one-cycle strobe when 8 bits have been received
//   rx_byte           received byte, valid with byte_done
//   tx_load           one-cycle strobe after tx_byte was loaded into the shifter
module sd_spi_byte_phy
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  input  logic [7:0] tx_byte,
  output logic       miso,
  output logic       cs_active,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       tx_load
);

  logic [1:0] cs_ff;
  logic [1:0] sclk_ff;
  logic [1:0] mosi_ff;
  logic       sclk_d;
  logic       cs_s;
  logic       sclk_rise;
  logic       sclk_fall;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_ff   <= 2'b11;
      sclk_ff <= 2'b00;
      mosi_ff <= 2'b11;
      sclk_d  <= 1'b0;
    end else begin
      cs_ff   <= {cs_ff[0], cs};
      sclk_ff <= {sclk_ff[0], sclk};
      mosi_ff <= {mosi_ff[0], mosi};
      sclk_d  <= sclk_ff[1];
    end
  end

  assign cs_s      = cs_ff[1];
  assign cs_active = ~cs_s;
  assign sclk_rise = sclk_ff[1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[1] & sclk_d;

  // A falling edge with bit_cnt==0 is the byte boundary: the previous byte's
  // eighth bit has been sampled, so the next byte's MSB goes out now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_shift  <= '0;
      rx_byte   <= '0;
      tx_shift  <= FILL_BYTE;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      tx_load   <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      tx_load   <= 1'b0;
      if (cs_s) begin
        bit_cnt  <= '0;
        tx_shift <= FILL_BYTE;
      end else begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[5:0], mosi_ff[1]};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
            rx_byte   <= {rx_shift, mosi_ff[1]};
          end
        end
        if (sclk_fall) begin
          if (bit_cnt == 3'd0) begin
            tx_shift <= tx_byte;
            tx_load  <= 1'b1;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b1};
          end
        end
      end
    end
  end

  // cs is folded in directly so miso is released as soon as the
  // synchronizer sees the deselect.
  assign miso = tx_shift[7] | cs_s;

endmodule

// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode command responder (init sequence + single-block read).
// Ports:
//   clk, reset        system clock, async active-high reset
//   cs, sclk, mosi    SPI host pins (mode 0, cs active low)
//   miso              card-to-host data, high when not transmitting
//   mem_rd            one-cycle read strobe to the block image store
//   mem_block         block address latched from a CMD17 argument
//   mem_byte          byte index within the block
//   mem_data          store read data, valid one clk after mem_rd
//   cmd_strobe        one-cycle pulse per complete command frame
//   last_cmd          index of the most recent command frame
//
// state    | meaning
// WAIT_CMD | idle, looking for a 01xxxxxx start byte
// RX_CMD   | collecting 4 argument bytes and the CRC byte
// NCR      | one 0xFF byte before the response
// TX_R1    | sending the R1 byte
// TX_EXTRA | sending 4 trailing bytes (CMD8 echo or OCR)
// TX_GAP   | 0xFF bytes between R1 and the data token
// TX_TOKEN | sending the 0xFE start token
// TX_DATA  | sending 512 block bytes from the store
// TX_CRC   | sending two 0xFF CRC bytes
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int ACMD41_BUSY_CNT = 2,
  parameter int NAC_BYTES       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        mem_rd,
  output logic [31:0] mem_block,
  output logic [8:0]  mem_byte,
  input  logic [7:0]  mem_data,
  output logic        cmd_strobe,
  output logic [5:0]  last_cmd
);

  localparam logic [9:0] NAC_M1 = (NAC_BYTES > 0) ? 10'(NAC_BYTES - 1) : 10'd0;

  sd_state_e   state, state_nxt;
  logic        cs_active;
  logic        byte_done;
  logic        tx_load;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic        frame_done;
  logic [9:0]  cnt;
  logic [5:0]  cmd_idx;
  logic [31:0] arg;
  logic [7:0]  r1;
  logic [31:0] extra_word;
  logic        has_extra;
  logic        has_data;
  logic        idle;
  logic        app;
  logic [15:0] acmd_cnt;
  logic [15:0] acmd_inc;
  logic        acmd_busy;
  logic        rd_d;
  logic [7:0]  data_buf;

  sd_spi_byte_phy u_phy (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .sclk      (sclk),
    .mosi      (mosi),
    .tx_byte   (tx_byte),
    .miso      (miso),
    .cs_active (cs_active),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .tx_load   (tx_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_CMD;
    else       state <= state_nxt;
  end

  // States advance on byte_done; tx_byte then holds the byte the phy will
  // load at the following byte boundary.
  always_comb begin
    state_nxt  = state;
    tx_byte    = FILL_BYTE;
    frame_done = 1'b0;
    case (state)
      WAIT_CMD: if (byte_done && rx_byte[7:6] == 2'b01) state_nxt = RX_CMD;
      RX_CMD: begin
        if (byte_done && cnt == '0) begin
          frame_done = 1'b1;
          state_nxt  = NCR;
        end
      end
      NCR: if (byte_done) state_nxt = TX_R1;
      TX_R1: begin
        tx_byte = r1;
        if (byte_done) begin
          if (has_extra)     state_nxt = TX_EXTRA;
          else if (has_data) state_nxt = (NAC_BYTES > 0) ? TX_GAP : TX_TOKEN;
          else               state_nxt = WAIT_CMD;
        end
      end
      TX_EXTRA: begin
        tx_byte = extra_word[31:24];
        if (byte_done && cnt == '0) state_nxt = WAIT_CMD;
      end
      TX_GAP: if (byte_done && cnt == '0) state_nxt = TX_TOKEN;
      TX_TOKEN: begin
        tx_byte = START_TOKEN;
        if (byte_done) state_nxt = TX_DATA;
      end
      TX_DATA: begin
        tx_byte = data_buf;
        if (byte_done && cnt == '0) state_nxt = TX_CRC;
      end
      TX_CRC: if (byte_done && cnt == '0) state_nxt = WAIT_CMD;
      default: state_nxt = WAIT_CMD;
    endcase
    if (!cs_active) begin
      state_nxt  = WAIT_CMD;
      frame_done = 1'b0;
    end
  end

  // Byte down-counter: loaded with (bytes-1) on state entry, the state
  // ends on the byte_done that finds it at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!cs_active) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        RX_CMD:   cnt <= 10'd4;
        TX_EXTRA: cnt <= 10'd3;
        TX_GAP:   cnt <= NAC_M1;
        TX_DATA:  cnt <= 10'd511;
        TX_CRC:   cnt <= 10'd1;
        default:  cnt <= '0;
      endcase
    end else if (byte_done && cnt != '0) begin
      cnt <= cnt - 10'd1;
    end
  end

  assign acmd_inc  = (acmd_cnt == 16'hFFFF) ? acmd_cnt : acmd_cnt + 16'd1;
  assign acmd_busy = (32'(acmd_inc) <= 32'(ACMD41_BUSY_CNT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_idx    <= '0;
      arg        <= '0;
      r1         <= r1_byte(1'b0, 1'b1);
      extra_word <= '0;
      has_extra  <= 1'b0;
      has_data   <= 1'b0;
      idle       <= 1'b1;
      app        <= 1'b0;
      acmd_cnt   <= '0;
      cmd_strobe <= 1'b0;
      last_cmd   <= '0;
      mem_block  <= '0;
      mem_byte   <= '0;
      mem_rd     <= 1'b0;
      rd_d       <= 1'b0;
      data_buf   <= '0;
    end else begin
      cmd_strobe <= 1'b0;
      mem_rd     <= 1'b0;
      rd_d       <= mem_rd;
      if (rd_d) data_buf <= mem_data;

      if (state == WAIT_CMD && state_nxt == RX_CMD) cmd_idx <= rx_byte[5:0];
      if (state == RX_CMD && byte_done && cnt != '0) arg <= {arg[23:0], rx_byte};
      if (state == TX_EXTRA && byte_done) extra_word <= {extra_word[23:0], 8'h00};

      if (frame_done) begin
        cmd_strobe <= 1'b1;
        last_cmd   <= cmd_idx;
        app        <= 1'b0;
        has_extra  <= 1'b0;
        has_data   <= 1'b0;
        case (cmd_idx)
          CMD_GO_IDLE: begin
            idle     <= 1'b1;
            acmd_cnt <= '0;
            r1       <= r1_byte(1'b0, 1'b1);
          end
          CMD_SEND_IF_COND: begin
            r1         <= r1_byte(1'b0, idle);
            extra_word <= {16'h0000, 8'h01, arg[7:0]};
            has_extra  <= 1'b1;
          end
          CMD_READ_OCR: begin
            r1         <= r1_byte(1'b0, idle);
            extra_word <= OCR_VALUE;
            has_extra  <= 1'b1;
          end
          CMD_APP_CMD: begin
            app <= 1'b1;
            r1  <= r1_byte(1'b0, idle);
          end
          CMD_SD_SEND_OP_COND: begin
            if (app) begin
              acmd_cnt <= acmd_inc;
              if (acmd_busy) begin
                r1 <= r1_byte(1'b0, 1'b1);
              end else begin
                idle <= 1'b0;
                r1   <= r1_byte(1'b0, 1'b0);
              end
            end else begin
              r1 <= r1_byte(1'b1, idle);
            end
          end
          CMD_READ_SINGLE: begin
            if (!idle) begin
              mem_block <= arg;
              mem_byte  <= '0;
              has_data  <= 1'b1;
              r1        <= r1_byte(1'b0, 1'b0);
            end else begin
              r1 <= r1_byte(1'b1, idle);
            end
          end
          default: r1 <= r1_byte(1'b1, idle);
        endcase
      end

      // Prefetch: reading byte n while the token or byte n-1 is shifting out
      // leaves several sclk periods for mem_data to reach data_buf.
      if (tx_load && cs_active) begin
        if (state == TX_TOKEN) begin
          mem_rd <= 1'b1;
        end else if (state == TX_DATA && cnt != '0) begin
          mem_rd   <= 1'b1;
          mem_byte <= mem_byte + 9'd1;
        end
      end
      if (state == TX_CRC && byte_done && cnt == '0 && cs_active) mem_byte <= '0;
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Self-checking bench for sd_spi_responder: drives SPI mode-0 frames with
// random fill/junk bytes and compares miso against a command-level model.
module tb_sd_spi_responder;

  localparam int BUSY = 2;
  localparam int NAC  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        mem_rd;
  logic [31:0] mem_block;
  logic [8:0]  mem_byte;
  logic [7:0]  mem_data;
  logic        cmd_strobe;
  logic [5:0]  last_cmd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_spi_responder #(.ACMD41_BUSY_CNT(BUSY), .NAC_BYTES(NAC)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .mem_rd     (mem_rd),
    .mem_block  (mem_block),
    .mem_byte   (mem_byte),
    .mem_data   (mem_data),
    .cmd_strobe (cmd_strobe),
    .last_cmd   (last_cmd)
  );

  // Block image store: content is byte index xor a per-test salt.
  logic [7:0] salt = 8'h00;
  logic [8:0] rd_q[$];
  int         strobe_cnt = 0;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= mem_byte[7:0] ^ salt;
      rd_q.push_back(mem_byte);
    end
    if (cmd_strobe) strobe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      wait_clk(4);
      rx[i] = miso;
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  // Card model at command level.
  bit          m_idle  = 1'b1;
  bit          m_app   = 1'b0;
  int          m_acnt  = 0;
  bit          m_data  = 1'b0;
  logic [31:0] m_block = '0;
  logic [7:0]  exp_q[$];

  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0] ill;
    logic [7:0] r1;
    ill    = m_idle ? 8'h05 : 8'h04;
    r1     = m_idle ? 8'h01 : 8'h00;
    m_data = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'hFF);
    case (idx)
      6'd0: begin
        m_idle = 1'b1;
        m_acnt = 0;
        exp_q.push_back(8'h01);
      end
      6'd8: begin
        exp_q.push_back(r1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        exp_q.push_back(arg[7:0]);
      end
      6'd55: exp_q.push_back(r1);
      6'd58: begin
        exp_q.push_back(r1);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h00);
      end
      6'd41: begin
        if (m_app) begin
          m_acnt++;
          if (m_acnt <= BUSY) exp_q.push_back(8'h01);
          else begin
            m_idle = 1'b0;
            exp_q.push_back(8'h00);
          end
        end else begin
          exp_q.push_back(ill);
        end
      end
      6'd17: begin
        if (!m_idle) begin
          m_data  = 1'b1;
          m_block = arg;
          exp_q.push_back(8'h00);
          repeat (NAC) exp_q.push_back(8'hFF);
          exp_q.push_back(8'hFE);
          for (int i = 0; i < 512; i++) exp_q.push_back(8'(i) ^ salt);
          exp_q.push_back(8'hFF);
          exp_q.push_back(8'hFF);
        end else begin
          exp_q.push_back(ill);
        end
      end
      default: exp_q.push_back(ill);
    endcase
    m_app = (idx == 6'd55);
  endtask

  // abort_after < 0: full response then one trailing byte; otherwise cs is
  // raised after that many response bytes.
  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input int abort_after);
    logic [7:0] rx;
    logic [7:0] junk;
    logic [7:0] frame [6];
    int         n0;
    int         nexp;
    int         bad;
    model_cmd(idx, arg);
    n0 = strobe_cnt;
    rd_q.delete();
    cs = 1'b0;
    wait_clk(4);
    repeat ($urandom_range(0, 2)) begin
      junk = 8'($urandom);
      if (junk[7:6] == 2'b01) junk[7] = 1'b1;
      xfer(junk, rx);
      chk("junk_miso", {24'h0, rx}, 32'hFF);
    end
    frame[0] = {2'b01, idx};
    frame[1] = arg[31:24];
    frame[2] = arg[23:16];
    frame[3] = arg[15:8];
    frame[4] = arg[7:0];
    frame[5] = {7'($urandom), 1'b1};
    for (int i = 0; i < 6; i++) begin
      xfer(frame[i], rx);
      chk("frame_miso", {24'h0, rx}, 32'hFF);
    end
    nexp = (abort_after < 0) ? exp_q.size() : abort_after;
    for (int i = 0; i < nexp; i++) begin
      xfer(8'($urandom), rx);
      chk($sformatf("resp_cmd%0d_b%0d", idx, i), {24'h0, rx}, {24'h0, exp_q[i]});
    end
    if (abort_after < 0) begin
      xfer(8'hFF, rx);
      chk($sformatf("tail_cmd%0d", idx), {24'h0, rx}, 32'hFF);
      chk("rd_count", rd_q.size(), m_data ? 512 : 0);
    end
    bad = 0;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != 9'(i)) bad++;
    chk("rd_order", bad, 0);
    chk("strobe_count", strobe_cnt - n0, 1);
    chk("last_cmd", {26'h0, last_cmd}, {26'h0, idx});
    chk("mem_block", mem_block, m_block);
    cs = 1'b1;
    wait_clk(3);
    chk("miso_cs_high", {31'h0, miso}, 32'h1);
    wait_clk(4);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]  idx;
    logic [31:0] a;
    cs    = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b1;
    reset = 1'b1;
    wait_clk(3);
    chk("rst_miso", {31'h0, miso}, 32'h1);
    chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst_mem_block", mem_block, 32'h0);
    chk("rst_mem_byte", {23'h0, mem_byte}, 32'h0);
    chk("rst_cmd_strobe", {31'h0, cmd_strobe}, 32'h0);
    chk("rst_last_cmd", {26'h0, last_cmd}, 32'h0);
    reset = 1'b0;
    wait_clk(4);

    do_cmd(6'd17, $urandom, -1);
    do_cmd(6'd13, 32'h0, -1);
    do_cmd(6'd0, 32'h0, -1);
    do_cmd(6'd8, 32'h0000_01AA, -1);
    do_cmd(6'd8, $urandom, -1);
    do_cmd(6'd41, 32'h4000_0000, -1);
    repeat (3) begin
      do_cmd(6'd55, 32'h0, -1);
      do_cmd(6'd41, 32'h4000_0000, -1);
    end
    do_cmd(6'd58, 32'h0, -1);
    do_cmd(6'd13, 32'h0, -1);

    repeat (6) begin
      case ($urandom_range(0, 4))
        0: idx = 6'd8;
        1: idx = 6'd58;
        2: idx = 6'd55;
        3: idx = 6'd41;
        default: begin
          do idx = 6'($urandom_range(1, 63));
          while (idx inside {6'd8, 6'd17, 6'd41, 6'd55, 6'd58});
        end
      endcase
      do_cmd(idx, $urandom, -1);
    end

    salt = 8'h00;
    do_cmd(6'd17, 32'h0000_0005, -1);
    chk("mem_byte_after_read", {23'h0, mem_byte}, 32'h0);

    salt = 8'($urandom);
    a    = $urandom;
    do_cmd(6'd17, a, 3 + NAC + 100);

    do_cmd(6'd0, 32'h0, -1);
    do_cmd(6'd17, 32'h0000_0007, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
